// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, sequencer state encoding and byte-select helper
package alu_pkg;
   localparam int ALU_DW = 8;
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // picks byte i out of a word of up to 8 bytes
   function automatic logic [ALU_DW-1:0] byte_sel(input logic [63:0] w, input logic [2:0] i);
      return w[ALU_DW*i +: ALU_DW];
   endfunction
endpackage

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs a BYTES-wide operation through the shared 8-bit ALU, LSB byte first
module alu_word_sequencer
   import alu_pkg::*;
#(
   parameter int BYTES = 2,
   localparam int W = 8*BYTES,
   localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   func,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         carry_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         zero,
   output logic         negative,
   output logic [7:0]   alu_a,
   output logic [7:0]   alu_b,
   output logic         alu_ci,
   output logic [2:0]   alu_func,
   input  logic [7:0]   alu_result,
   input  logic         alu_co,
   input  logic         alu_zero,
   input  logic         alu_neg
);
   state_t r_state, w_next;
   logic [IW-1:0] r_idx;
   logic [2:0] r_func;
   logic [W-1:0] r_a, r_b, r_acc, r_result, w_acc;
   logic r_carry, r_zacc, r_co, r_zero, r_neg;
   logic w_run, w_last;
   assign w_run = r_state == RUN;
   assign w_last = r_idx == IW'(BYTES-1);
   assign busy = w_run;
   assign done = r_state == DONE;
   assign result = r_result;
   assign carry_out = r_co;
   assign zero = r_zero;
   assign negative = r_neg;
   assign alu_a = w_run ? byte_sel(64'(r_a), 3'(r_idx)) : '0;
   assign alu_b = w_run ? byte_sel(64'(r_b), 3'(r_idx)) : '0;
   assign alu_ci = w_run & r_carry;
   assign alu_func = w_run ? r_func : '0;
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   // next state: accept only in IDLE, one RUN cycle per byte, single DONE cycle
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? RUN : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         default: w_next = IDLE;
      endcase
   end
   // accumulator with the current ALU byte merged in, so the last byte reaches result directly
   always_comb begin
      w_acc = r_acc;
      w_acc[8*r_idx +: 8] = alu_result;
   end
   // operand latch, carry chain, zero accumulation and result/flag update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         r_func <= '0;
         r_a <= '0;
         r_b <= '0;
         r_acc <= '0;
         r_carry <= 1'b0;
         r_zacc <= 1'b0;
         r_result <= '0;
         r_co <= 1'b0;
         r_zero <= 1'b0;
         r_neg <= 1'b0;
      end else if (r_state == IDLE) begin
         if (start) begin
            r_idx <= '0;
            r_func <= func;
            r_a <= op_a;
            r_b <= op_b;
            r_acc <= '0;
            r_carry <= carry_in;
            r_zacc <= 1'b1;
         end
      end else if (w_run) begin
         r_acc <= w_acc;
         r_carry <= alu_co;
         r_zacc <= r_zacc & alu_zero;
         if (w_last) begin
            r_result <= w_acc;
            r_co <= alu_co;
            r_neg <= alu_neg;
            r_zero <= r_zacc & alu_zero;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb_alu_word_sequencer: scoreboard bench with a word-level reference model and a byte ALU model
module tb_alu_word_sequencer;
   import alu_pkg::*;
   localparam int BYTES = 2;
   localparam int W = 8*BYTES;
   logic clk = 0, rst = 1, start = 0, carry_in = 0;
   logic [2:0] func = 0;
   logic [W-1:0] op_a = 0, op_b = 0;
   logic busy, done, carry_out, zero, negative, alu_ci, alu_co, alu_zero, alu_neg;
   logic [W-1:0] result;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_func;
   int n_tests = 0, n_fail = 0;
   logic [W+2:0] q[$];
   logic [W+2:0] m_last = '0;
   int m_cnt = 0;
   logic [2:0] m_func;
   logic [W-1:0] m_a, m_b;
   logic m_ci;

   always #5 clk = ~clk;

   alu_word_sequencer #(.BYTES(BYTES)) dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .op_a(op_a), .op_b(op_b),
      .carry_in(carry_in), .busy(busy), .done(done), .result(result),
      .carry_out(carry_out), .zero(zero), .negative(negative),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_func(alu_func),
      .alu_result(alu_result), .alu_co(alu_co), .alu_zero(alu_zero), .alu_neg(alu_neg)
   );

   // 8-bit ALU: SUB is A + ~B + carryIn, logic ops produce carryOut 0
   always_comb begin
      {alu_co, alu_result} = 9'd0;
      case (alu_func)
         ALU_ADD: {alu_co, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_ci);
         ALU_SUB: {alu_co, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'(alu_ci);
         ALU_AND: alu_result = alu_a & alu_b;
         ALU_OR:  alu_result = alu_a | alu_b;
         ALU_XOR: alu_result = alu_a ^ alu_b;
         default: alu_result = 8'd0;
      endcase
      alu_zero = alu_result == 8'd0;
      alu_neg = alu_result[7];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // whole-word reference: returns {carry, zero, negative, result}
   function automatic logic [W+2:0] ref_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      logic [W:0] s;
      case (f)
         ALU_ADD: s = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
         ALU_SUB: s = {1'b0, a} + {1'b0, ~b} + (W+1)'(ci);
         ALU_AND: s = {1'b0, a & b};
         ALU_OR:  s = {1'b0, a | b};
         ALU_XOR: s = {1'b0, a ^ b};
         default: s = '0;
      endcase
      return {s[W], s[W-1:0] == '0, s[W-1], s[W-1:0]};
   endfunction

   // carry entering byte k: carry out of the low k bytes of the whole-word operation
   function automatic logic exp_ci(input int k);
      logic [W:0] mask, s;
      if (k == 0) return m_ci;
      mask = '1;
      mask = mask >> (W + 1 - 8*k);
      case (m_func)
         ALU_ADD: s = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + (W+1)'(m_ci);
         ALU_SUB: s = ({1'b0, m_a} & mask) + ({1'b0, ~m_b} & mask) + (W+1)'(m_ci);
         default: s = '0;
      endcase
      return s[8*k];
   endfunction

   // protocol model: m_cnt 0 = idle, 1..BYTES = byte cycles, BYTES+1 = completion cycle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0;
         q.delete();
      end else if (m_cnt == 0) begin
         if (start) begin
            m_func = func;
            m_a = op_a;
            m_b = op_b;
            m_ci = carry_in;
            q.push_back(ref_op(func, op_a, op_b, carry_in));
            m_cnt = 1;
         end
      end else begin
         m_cnt = (m_cnt == BYTES + 1) ? 0 : m_cnt + 1;
      end
   end

   // monitor: pops the scoreboard on done and checks held outputs and ALU drive every cycle
   always @(negedge clk) begin
      if (rst) begin
         m_last = '0;
      end else begin
         chk("busy", 64'(busy), 64'(m_cnt >= 1 && m_cnt <= BYTES));
         chk("done", 64'(done), 64'(m_cnt == BYTES + 1));
         if (done) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL scoreboard: done with no expected entry");
            end else begin
               m_last = q.pop_front();
            end
         end
         chk("outputs", 64'({carry_out, zero, negative, result}), 64'(m_last));
         if (m_cnt >= 1 && m_cnt <= BYTES) begin
            chk("alu_bus", 64'({alu_func, alu_a, alu_b}), 64'({m_func, m_a[8*(m_cnt-1) +: 8], m_b[8*(m_cnt-1) +: 8]}));
            chk("alu_ci", 64'(alu_ci), 64'(exp_ci(m_cnt - 1)));
         end else begin
            chk("alu_idle", 64'({alu_func, alu_a, alu_b, alu_ci}), 64'(0));
         end
      end
   end

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] exp_res, input logic [2:0] exp_flags);
      int n;
      @(negedge clk);
      start = 1; func = ALU_ADD; op_a = a; op_b = b; carry_in = ci;
      @(negedge clk);
      start = 0;
      n = 1;
      while (!done && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, 64'(n), 64'(BYTES + 1));
      chk(name, 64'({carry_out, zero, negative, result}), 64'({exp_flags, exp_res}));
   endtask

   initial begin
      int n, dones;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 64'({busy, done, result, carry_out, zero, negative, alu_a, alu_b, alu_ci, alu_func}), 64'(0));
      #2 rst = 0;
      run_op("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 3'b000);
      run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 3'b110);
      run_op("add_7f00_0100", 16'h7F00, 16'h0100, 1'b0, 16'h8000, 3'b001);
      run_op("add_00fe_ci", 16'h00FE, 16'h0001, 1'b1, 16'h0100, 3'b000);
      @(negedge clk);
      start = 1; func = ALU_ADD; op_a = 16'h1234; op_b = 16'h0001; carry_in = 0;
      @(negedge clk);
      start = 1; func = ALU_SUB; op_a = 16'h0000; op_b = 16'h0000; carry_in = 1;
      @(negedge clk);
      start = 0;
      n = 2;
      while (!done && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ignore_start_latency", 64'(n), 64'(BYTES + 1));
      chk("ignore_start_result", 64'(result), 64'(16'h1235));
      @(negedge clk);
      start = 1; func = ALU_ADD; op_a = 16'h00FF; op_b = 16'h0001; carry_in = 0;
      @(posedge clk);
      #2 rst = 1;
      start = 0;
      #1 chk("reset_abort", 64'({busy, done, result, carry_out, zero, negative, alu_a, alu_b, alu_ci, alu_func}), 64'(0));
      @(negedge clk);
      #2 rst = 0;
      run_op("add_after_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 3'b000);
      @(negedge clk);
      start = 1; func = ALU_ADD;
      dones = 0;
      repeat (16) begin
         @(negedge clk);
         dones += int'(done);
         op_a = W'($urandom); op_b = W'($urandom); carry_in = 1'($urandom);
      end
      start = 0;
      chk("back_to_back_dones", 64'(dones), 64'(4));
      repeat (1500) begin
         @(negedge clk);
         start = $urandom_range(0, 2) == 0;
         func = 3'($urandom_range(0, 7));
         op_a = W'($urandom); op_b = W'($urandom); carry_in = 1'($urandom);
      end
      start = 0;
      repeat (BYTES + 4) @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
